// File: rtl/imem_sync.sv
// -----------------------------------------------------------------------------
// imem_sync -- synchronous instruction memory for the 5-stage core.
//
// Sits between PC/IF and the IF/ID register. The memory is word-organised
// (32-bit, little-endian) and has a one-cycle registered fetch with stall and
// flush. A run-time program-load port writes the array. Fetches are refused
// while a load is in progress. Out-of-range fetches return OOR_WORD (HALT by
// default), so a runaway PC stops the pipe.
//
// Optional feature macro: IMEM_MISALIGN_TRAP_EN
//   defined   : a fetch with fetch_addr[1:0] != 0 returns OOR_WORD and sets
//               misalign.
//   undefined : fetch_addr[1:0] is ignored (word-aligned read) and misalign
//               is always 0.
//
// Ports
//   clk          in   1        clock; all state changes on the rising edge
//   rst          in   1        synchronous, active-high reset
//   fetch_req    in   1        IF requests the instruction at fetch_addr
//   fetch_addr   in   32       byte address (PC)
//   fetch_stall  in   1        hold the current fetch result
//   fetch_flush  in   1        kill the in-flight fetch (overrides stall)
//   instr_out    out  32       fetched instruction
//   instr_valid  out  1        instr_out is a valid fetch result
//   misalign     out  1        returned fetch was misaligned (trap build only)
//   prog_we      in   1        write prog_wdata to word prog_idx
//   prog_idx     in   IDX_W+1  word index for the program write
//   prog_wdata   in   32       instruction word to write
//   prog_last    in   1        qualifies prog_we: final word of the burst
//   prog_busy    out  1        load in progress; fetches are refused
//   prog_count   out  IDX_W+1  in-range words written since the load started
//   prog_err     out  1        sticky: an out-of-range prog_idx was written
// -----------------------------------------------------------------------------
module imem_sync #(
  parameter int          DEPTH_WORDS = 32,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0013,
  parameter logic [31:0] OOR_WORD    = 32'h0000_007F,
  localparam int         IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_req,
  input  logic [31:0]      fetch_addr,
  input  logic             fetch_stall,
  input  logic             fetch_flush,
  output logic [31:0]      instr_out,
  output logic             instr_valid,
  output logic             misalign,
  input  logic             prog_we,
  input  logic [IDX_W:0]   prog_idx,
  input  logic [31:0]      prog_wdata,
  input  logic             prog_last,
  output logic             prog_busy,
  output logic [IDX_W:0]   prog_count,
  output logic             prog_err
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PROG  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W + 1)'(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];

  state_e         state_q, state_d;
  logic [31:0]    instr_q, instr_d;
  logic           valid_q, valid_d;
  logic           mis_q, mis_d;
  logic           busy_q, busy_d;
  logic [IDX_W:0] count_q, count_d;
  logic           err_q, err_d;
  logic           mem_we;

  // Fetch address decode. The range test uses the full word address, so a
  // high PC cannot alias back into the array through the truncated index.
  logic [29:0]      fetch_word;
  logic [IDX_W-1:0] fetch_idx;
  logic             fetch_oor;
  logic             fetch_mis;
  logic             prog_oor;

  assign fetch_word = fetch_addr[31:2];
  assign fetch_idx  = fetch_addr[IDX_W+1:2];
  assign fetch_oor  = (fetch_word >= 30'(DEPTH_WORDS));
  assign prog_oor   = (prog_idx >= DEPTH_CNT);

`ifdef IMEM_MISALIGN_TRAP_EN
  assign fetch_mis = (fetch_addr[1:0] != 2'b00);
`else
  // Byte offset is deliberately ignored in this build.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^fetch_addr[1:0];
  assign fetch_mis       = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    instr_d = instr_q;
    valid_d = 1'b0;
    mis_d   = mis_q;
    count_d = count_q;
    err_d   = err_q;
    mem_we  = 1'b0;

    // Program-load sequencing.
    unique case (state_q)
      ST_RUN: begin
        if (prog_we) begin
          // The first write of a burst restarts the count and the error flag.
          mem_we  = !prog_oor;
          count_d = prog_oor ? '0 : (IDX_W + 1)'(1);
          err_d   = prog_oor;
          state_d = prog_last ? ST_DRAIN : ST_PROG;
        end
      end
      ST_PROG: begin
        if (prog_we) begin
          mem_we = !prog_oor;
          if (!prog_oor && (count_q < DEPTH_CNT)) begin
            count_d = count_q + 1'b1;
          end
          err_d = err_q | prog_oor;
          if (prog_last) begin
            state_d = ST_DRAIN;
          end
        end
      end
      // DRAIN separates the last write from the first fetch, so a read can
      // never meet a write to the same word.
      ST_DRAIN: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    // Fetch path. Priority is load > flush > stall > request.
    if ((state_q != ST_RUN) || prog_we) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      mis_d   = 1'b0;
    end else if (fetch_flush) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
      mis_d   = 1'b0;
    end else if (fetch_stall) begin
      valid_d = valid_q;
    end else if (fetch_req) begin
      valid_d = 1'b1;
      mis_d   = fetch_mis;
      instr_d = (fetch_oor || fetch_mis) ? OOR_WORD : mem[fetch_idx];
    end

    busy_d = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments, so every flop
    // samples values from before this edge regardless of statement order.
    if (rst) begin
      state_q <= ST_RUN;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset. This keeps it mappable to RAM, and a reset
  // in the middle of a load leaves the words already written in place.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[prog_idx[IDX_W-1:0]] <= prog_wdata;
    end
  end

  assign instr_out   = instr_q;
  assign instr_valid = valid_q;
  assign misalign    = mis_q;
  assign prog_busy   = busy_q;
  assign prog_count  = count_q;
  assign prog_err    = err_q;

endmodule

// File: tb/tb_imem_sync.sv
// -----------------------------------------------------------------------------
// tb_imem_sync -- self-checking bench for imem_sync.
//
// A behavioural model tracks the array contents, whether a load burst or its
// drain cycle is under way, and what each output must be after every edge.
// A compare process checks all outputs against the model on every falling
// edge. Directed sequences pin the model with literal values. A long
// randomized phase then follows.
// -----------------------------------------------------------------------------
module tb_imem_sync;

  localparam int          DEPTH = 32;
  localparam int          IW    = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam logic [31:0] OOR   = 32'h0000_007F;
`ifdef IMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_stall;
  logic          fetch_flush;
  logic [31:0]   instr_out;
  logic          instr_valid;
  logic          misalign;
  logic          prog_we;
  logic [IW:0]   prog_idx;
  logic [31:0]   prog_wdata;
  logic          prog_last;
  logic          prog_busy;
  logic [IW:0]   prog_count;
  logic          prog_err;

  imem_sync #(.DEPTH_WORDS(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_stall (fetch_stall),
    .fetch_flush (fetch_flush),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .misalign    (misalign),
    .prog_we     (prog_we),
    .prog_idx    (prog_idx),
    .prog_wdata  (prog_wdata),
    .prog_last   (prog_last),
    .prog_busy   (prog_busy),
    .prog_count  (prog_count),
    .prog_err    (prog_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem   [DEPTH];
  bit          m_known [DEPTH];
  bit          m_loading = 0;   // inside a load burst, last word not yet seen
  bit          m_drain   = 0;   // the single cycle after the last word
  logic [31:0] e_out     = NOP;
  bit          e_known   = 1;
  bit          e_valid   = 0;
  bit          e_mis     = 0;
  bit          e_busy    = 0;
  int          e_cnt     = 0;
  bit          e_err     = 0;
  bit          check_en  = 0;

  always @(posedge clk) begin
    bit          running;
    int unsigned word;
    bit          mis;
    running = !m_loading && !m_drain;
    if (rst) begin
      m_loading = 0; m_drain = 0;
      e_out = NOP; e_known = 1; e_valid = 0; e_mis = 0;
      e_busy = 0; e_cnt = 0; e_err = 0;
    end else begin
      if (!running || prog_we || fetch_flush) begin
        e_out = NOP; e_known = 1; e_valid = 0; e_mis = 0;
      end else if (fetch_stall) begin
        // everything holds
      end else if (fetch_req) begin
        word    = fetch_addr[31:2];
        mis     = TRAP && (fetch_addr[1:0] != 2'b00);
        e_valid = 1;
        e_mis   = mis;
        if (mis || word >= DEPTH) begin
          e_out = OOR; e_known = 1;
        end else begin
          e_out = m_mem[word]; e_known = m_known[word];
        end
      end else begin
        e_valid = 0;
      end

      if (m_drain) begin
        m_drain = 0;
      end else if (prog_we) begin
        if (running) begin e_cnt = 0; e_err = 0; end
        if (prog_idx < DEPTH) begin
          m_mem[prog_idx]   = prog_wdata;
          m_known[prog_idx] = 1;
          if (e_cnt < DEPTH) e_cnt++;
        end else begin
          e_err = 1;
        end
        m_loading = !prog_last;
        m_drain   = prog_last;
      end
      e_busy = m_loading || m_drain;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("instr_valid", {31'd0, instr_valid}, {31'd0, e_valid});
      check("misalign",    {31'd0, misalign},    {31'd0, e_mis});
      check("prog_busy",   {31'd0, prog_busy},   {31'd0, e_busy});
      check("prog_err",    {31'd0, prog_err},    {31'd0, e_err});
      check("prog_count",  32'(prog_count),      32'(e_cnt));
      if (e_known) check("instr_out", instr_out, e_out);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req = 0; fetch_addr = '0; fetch_stall = 0; fetch_flush = 0;
    prog_we = 0; prog_idx = '0; prog_wdata = '0; prog_last = 0;
  endtask

  task automatic prog(input int idx, input logic [31:0] data, input bit last);
    prog_we = 1; prog_idx = (IW + 1)'(idx); prog_wdata = data; prog_last = last;
  endtask

  task automatic req(input logic [31:0] addr);
    fetch_req = 1; fetch_addr = addr;
  endtask

  logic [31:0] w [4];

  initial begin
    w[0] = 32'h0050_0093; w[1] = 32'h00A0_0113;
    w[2] = 32'h0020_81B3; w[3] = 32'h4011_0233;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

    idle_inputs();
    rst = 1;
    cyc();
    check_en = 1;
    cyc();
    rst = 0;

    // Reset state, then idle cycles with no request.
    check("rst_instr", instr_out, 32'h13);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_count", 32'(prog_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("idle_instr", instr_out, 32'h13);
      check("idle_busy",  {31'd0, prog_busy}, 32'd0);
    end

    // Load words 0..3; busy covers three PROG cycles plus one DRAIN cycle.
    for (int i = 0; i < 4; i++) begin
      prog(i, w[i], i == 3);
      cyc();
      check("load_busy", {31'd0, prog_busy}, 32'd1);
    end
    idle_inputs();
    cyc();
    check("load_busy_drop", {31'd0, prog_busy}, 32'd0);
    check("load_count", 32'(prog_count), 32'd4);

    for (int i = 0; i < 4; i++) begin
      req(32'(4 * i));
      cyc();
      check("fetch_word", instr_out, w[i]);
      check("fetch_valid", {31'd0, instr_valid}, 32'd1);
    end

    // Stall holds word1 while a new request for PC=8 waits.
    req(32'd4);
    cyc();
    fetch_stall = 1;
    req(32'd8);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_hold", instr_out, w[1]);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    fetch_stall = 0;
    cyc();
    check("stall_release", instr_out, w[2]);

    // Flush overrides a simultaneous stall; then an out-of-range PC.
    fetch_stall = 1; fetch_flush = 1;
    cyc();
    check("flush_instr", instr_out, 32'h13);
    check("flush_valid", {31'd0, instr_valid}, 32'd0);
    fetch_stall = 0; fetch_flush = 0;
    req(32'(4 * DEPTH));
    cyc();
    check("oor_instr", instr_out, 32'h7F);
    check("oor_valid", {31'd0, instr_valid}, 32'd1);

    // Out-of-range write inside a burst, then reset mid-load.
    idle_inputs();
    prog(0, w[0], 0);
    cyc();
    prog(DEPTH, 32'hDEAD_BEEF, 0);
    cyc();
    check("oor_wr_err", {31'd0, prog_err}, 32'd1);
    check("oor_wr_count", 32'(prog_count), 32'd1);
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
    check("midrst_busy", {31'd0, prog_busy}, 32'd0);
    check("midrst_err", {31'd0, prog_err}, 32'd0);
    check("midrst_count", 32'(prog_count), 32'd0);

    // A single prog_we with prog_last goes straight from RUN to DRAIN.
    prog(1, w[1], 1);
    cyc();
    check("single_busy", {31'd0, prog_busy}, 32'd1);
    check("single_count", 32'(prog_count), 32'd1);
    idle_inputs();
    cyc();

    // Misaligned fetch.
    req(32'd2);
    cyc();
    check("mis_instr", instr_out, TRAP ? 32'h7F : w[0]);
    check("mis_flag", {31'd0, misalign}, {31'd0, TRAP});

    // Fill the whole array so that every later fetch has a known word.
    idle_inputs();
    for (int i = 0; i < DEPTH; i++) begin
      prog(i, $urandom, i == DEPTH - 1);
      cyc();
    end
    idle_inputs();
    cyc();
    check("full_count", 32'(prog_count), 32'(DEPTH));

    // Randomized traffic.
    for (int n = 0; n < 4000; n++) begin
      int kind;
      rst         = ($urandom_range(0, 299) == 0);
      fetch_req   = ($urandom_range(0, 3) != 0);
      fetch_stall = ($urandom_range(0, 5) == 0);
      fetch_flush = ($urandom_range(0, 9) == 0);
      kind = $urandom_range(0, 7);
      if (kind <= 5)      fetch_addr = {$urandom_range(0, DEPTH - 1), 2'b00};
      else if (kind == 6) fetch_addr = {$urandom_range(0, DEPTH - 1), 2'($urandom_range(1, 3))};
      else                fetch_addr = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(DEPTH, DEPTH + 8)) << 2
                                                                 : $urandom;
      prog_we    = ($urandom_range(0, 31) == 0) || (e_busy && ($urandom_range(0, 1) != 0));
      prog_idx   = (IW + 1)'($urandom_range(0, DEPTH + 1));
      prog_wdata = $urandom;
      prog_last  = ($urandom_range(0, 3) == 0);
      cyc();
    end
    idle_inputs();
    rst = 0;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
